// File: rtl/data_mem_pkg.sv
// Shared definitions for DataMemory and its copy-engine bus master.
// The state encoding is private to the engine; the widths are shared by every DataMemory user.
package data_mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/data_mem_copy_engine.sv
// Byte-serial block copy inside DataMemory: one read/write pair per byte, strictly ascending.
// Every output is registered; memory strobes drop straight away on an asynchronous reset.
module data_mem_copy_engine
    import data_mem_pkg::*;
#(
    parameter int AW       = ADDR_W,
    parameter int DW       = DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   bytes_done,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_datain,
    output logic          mem_w,
    output logic          mem_r,
    input  logic [DW-1:0] mem_dataout
);

    localparam int WCW = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW:0]   rem_q, rem_d;
    logic [AW:0]   bytes_done_q, bytes_done_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic [AW-1:0] mem_adr_q, mem_adr_d;
    logic [DW-1:0] mem_datain_q, mem_datain_d;
    logic          mem_w_q, mem_w_d;
    logic          mem_r_q, mem_r_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          last_byte;
    logic          wait_over;

    assign last_byte = (rem_q == (AW+1)'(1));
    assign wait_over = (wait_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            rem_q        <= '0;
            bytes_done_q <= '0;
            wait_q       <= '0;
            mem_adr_q    <= '0;
            mem_datain_q <= '0;
            mem_w_q      <= 1'b0;
            mem_r_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            rem_q        <= rem_d;
            bytes_done_q <= bytes_done_d;
            wait_q       <= wait_d;
            mem_adr_q    <= mem_adr_d;
            mem_datain_q <= mem_datain_d;
            mem_w_q      <= mem_w_d;
            mem_r_q      <= mem_r_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (len == '0) ? DONE : RD;
            RD:      state_d = WAIT;
            WAIT:    if (wait_over) state_d = WR;
            WR:      state_d = last_byte ? DONE : RD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are loaded on the edge that enters the state they belong to.
    always_comb begin
        src_d        = src_q;
        dst_d        = dst_q;
        rem_d        = rem_q;
        bytes_done_d = bytes_done_q;
        wait_d       = wait_q;
        mem_adr_d    = mem_adr_q;
        mem_datain_d = mem_datain_q;
        mem_w_d      = 1'b0;
        mem_r_d      = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bytes_done_d = '0;
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        src_d     = src_addr;
                        dst_d     = dst_addr;
                        rem_d     = len;
                        busy_d    = 1'b1;
                        mem_adr_d = src_addr;
                        mem_r_d   = 1'b1;
                    end
                end
            end
            RD: begin
                // One extra WAIT cycle beyond READ_LAT lets the byte land in the datain register.
                wait_d = WCW'(READ_LAT);
            end
            WAIT: begin
                if (wait_over) begin
                    mem_adr_d    = dst_q;
                    mem_datain_d = mem_dataout;
                    mem_w_d      = 1'b1;
                end else begin
                    wait_d = wait_q - WCW'(1);
                end
            end
            WR: begin
                src_d        = src_q + AW'(1);
                dst_d        = dst_q + AW'(1);
                rem_d        = rem_q - (AW+1)'(1);
                bytes_done_d = bytes_done_q + (AW+1)'(1);
                if (last_byte) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    mem_adr_d = src_q + AW'(1);
                    mem_r_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign bytes_done = bytes_done_q;
    assign mem_adr    = mem_adr_q;
    assign mem_datain = mem_datain_q;
    assign mem_w      = mem_w_q;
    assign mem_r      = mem_r_q;

endmodule
